// File: rtl/rsnn_ctrl.sv
// Timestep and configuration controller for one recurrent spiking neuron.
// Parameters are double-buffered and swapped atomically at step boundaries.
module rsnn_ctrl #(
    parameter int STEP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_addr,
    input  logic [7:0]            cfg_data,
    input  logic                  run,
    input  logic                  spike_in,
    output logic                  neuron_enable,
    output logic [7:0]            threshold,
    output logic [7:0]            decay,
    output logic [7:0]            refractory_period,
    output logic [7:0]            feedback_scale,
    output logic [7:0]            spike_count,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic                  commit_pending
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [7:0] sh_thr, sh_dec, sh_ref, sh_fb, sh_per;
    logic [7:0] step_period, per_eff, cnt;
    logic       cfg_fire, apply, start, strobe_nx, sample;

    assign cfg_ready = !commit_pending;
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        apply     = 1'b0;
        strobe_nx = 1'b0;
        unique case (state)
            IDLE: begin
                apply = commit_pending;
                if (run) begin
                    state_nx = RUN;
                    start    = 1'b1;
                end
            end
            RUN: begin
                apply = commit_pending && neuron_enable;
                if (!run) state_nx = IDLE;
            end
        endcase
        // The timestep after a boundary commit already runs on the new period.
        per_eff = apply ? sh_per : step_period;
        if (state == RUN && run && cnt == per_eff) strobe_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            neuron_enable <= 1'b0;
            cnt           <= '0;
            sample        <= 1'b0;
            step_count    <= '0;
            spike_count   <= '0;
        end else begin
            state         <= state_nx;
            neuron_enable <= strobe_nx;
            sample        <= neuron_enable;
            if (state_nx == RUN && !start && !strobe_nx)
                cnt <= cnt + 8'd1;
            else
                cnt <= '0;
            if (start)
                step_count <= '0;
            else if (strobe_nx)
                step_count <= step_count + STEP_CNT_W'(1);
            if (start)
                spike_count <= '0;
            else if (sample && spike_in && spike_count != 8'hff)
                spike_count <= spike_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_pending    <= 1'b0;
            sh_thr            <= 8'd64;
            sh_dec            <= 8'd1;
            sh_ref            <= 8'd2;
            sh_fb             <= 8'd0;
            sh_per            <= 8'd0;
            threshold         <= 8'd64;
            decay             <= 8'd1;
            refractory_period <= 8'd2;
            feedback_scale    <= 8'd0;
            step_period       <= 8'd0;
        end else begin
            if (apply) begin
                commit_pending    <= 1'b0;
                threshold         <= sh_thr;
                decay             <= sh_dec;
                refractory_period <= sh_ref;
                feedback_scale    <= sh_fb;
                step_period       <= sh_per;
            end
            if (cfg_fire) begin
                unique case (cfg_addr)
                    3'd0: sh_thr <= cfg_data;
                    3'd1: sh_dec <= cfg_data;
                    3'd2: sh_ref <= cfg_data;
                    3'd3: sh_fb  <= cfg_data;
                    3'd4: sh_per <= cfg_data;
                    3'd5: commit_pending <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsnn_ctrl.sv
// Directed bench for rsnn_ctrl with an edge-numbered reference model.
module tb_rsnn_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        run = 1'b0;
    logic        spike_in = 1'b0;
    logic        neuron_enable;
    logic [7:0]  threshold, decay, refractory_period, feedback_scale;
    logic [7:0]  spike_count;
    logic [15:0] step_count;
    logic        commit_pending;

    int checks = 0;
    int failures = 0;

    rsnn_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .run               (run),
        .spike_in          (spike_in),
        .neuron_enable     (neuron_enable),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .feedback_scale    (feedback_scale),
        .spike_count       (spike_count),
        .step_count        (step_count),
        .commit_pending    (commit_pending)
    );

    always #5 clk = ~clk;

    // Reference model: timesteps are tracked as absolute edge numbers.
    int          e;
    bit          m_run, m_en, m_pend, acc, app;
    logic [7:0]  sh[5];
    logic [7:0]  act[5];
    int          last_ref;
    int          smp_q[$];
    int          m_spk;
    logic [15:0] m_step;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e = 0; m_run = 0; m_en = 0; m_pend = 0;
            sh[0] = 64; sh[1] = 1; sh[2] = 2; sh[3] = 0; sh[4] = 0;
            for (int i = 0; i < 5; i++) act[i] = sh[i];
            last_ref = 0; m_spk = 0; m_step = 0;
            smp_q.delete();
        end else begin
            e++;
            acc = cfg_valid && !m_pend;
            app = m_pend && (!m_run || m_en);
            if (app) for (int i = 0; i < 5; i++) act[i] = sh[i];
            if (smp_q.size() > 0 && smp_q[0] == e) begin
                void'(smp_q.pop_front());
                if (spike_in && m_spk < 255) m_spk++;
            end
            if (!m_run) begin
                m_en = 0;
                if (run) begin
                    m_run = 1; m_step = 0; m_spk = 0; last_ref = e;
                end
            end else if (!run) begin
                m_run = 0; m_en = 0;
            end else if (e - last_ref == int'(act[4]) + 1) begin
                m_en = 1; m_step++; last_ref = e;
                smp_q.push_back(e + 2);
            end else begin
                m_en = 0;
            end
            if (app) m_pend = 0;
            if (acc) begin
                if (cfg_addr == 3'd5) m_pend = 1;
                else if (cfg_addr < 3'd5) sh[int'(cfg_addr)] = cfg_data;
            end
        end
    end

    logic [58:0] exp_v, got_v;
    always @(negedge clk) begin
        exp_v = {act[0], act[1], act[2], act[3], m_en, !m_pend, m_pend,
                 8'(m_spk), m_step};
        got_v = {threshold, decay, refractory_period, feedback_scale,
                 neuron_enable, cfg_ready, commit_pending, spike_count,
                 step_count};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL cycle t=%0t got=%h want=%h", $time, got_v, exp_v);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        cyc(2);
        chk("rst_thr", threshold, 64);
        chk("rst_decay", decay, 1);
        chk("rst_refr", refractory_period, 2);
        chk("rst_fb", feedback_scale, 0);
        chk("rst_en", neuron_enable, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_spk", spike_count, 0);
        chk("rst_step", step_count, 0);
        reset = 1'b0;
        cyc(1);

        // Idle commit
        wr(0, 100);
        chk("idle_thr_shadow", threshold, 64);
        wr(5, 0);
        chk("idle_ready_low", cfg_ready, 0);
        chk("idle_thr_pending", threshold, 64);
        cyc(1);
        chk("idle_thr_new", threshold, 100);
        chk("idle_ready_back", cfg_ready, 1);

        // Period 3 run
        wr(4, 3);
        wr(5, 0);
        cyc(1);
        run = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (i == 4) chk("first_strobe_pre", neuron_enable, 0);
            if (i == 5) chk("first_strobe", neuron_enable, 1);
        end
        chk("step_after_20", step_count, 5);

        // Commit mid-step while running
        cyc(1);
        wr(0, 90);
        cfg_valid = 1'b1; cfg_addr = 3'd5;
        @(negedge clk);
        chk("run_pending", commit_pending, 1);
        cfg_addr = 3'd0; cfg_data = 8'd55;
        @(negedge clk);
        chk("run_strobe_old_en", neuron_enable, 1);
        chk("run_strobe_old_thr", threshold, 100);
        chk("run_blocked", cfg_ready, 0);
        @(negedge clk);
        chk("run_thr_new", threshold, 90);
        chk("run_ready_back", cfg_ready, 1);
        cfg_valid = 1'b0;

        // Saturation with period 0
        run = 1'b0;
        cyc(2);
        wr(4, 0);
        wr(5, 0);
        cyc(1);
        spike_in = 1'b1;
        run = 1'b1;
        cyc(301);
        chk("sat_step", step_count, 300);
        chk("sat_spk", spike_count, 255);
        chk("sat_thr_kept", threshold, 90);
        run = 1'b0;
        spike_in = 1'b0;
        cyc(3);

        // Run drop with a commit pending
        wr(4, 3);
        wr(5, 0);
        cyc(1);
        run = 1'b1;
        cyc(1);
        chk("reentry_spk_clr", spike_count, 0);
        cyc(4);
        chk("drop_strobe", neuron_enable, 1);
        wr(0, 77);
        cfg_valid = 1'b1; cfg_addr = 3'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("drop_en", neuron_enable, 0);
        chk("drop_thr_old", threshold, 90);
        chk("drop_pend", commit_pending, 1);
        @(negedge clk);
        chk("drop_thr_new", threshold, 77);
        chk("drop_pend_clr", commit_pending, 0);
        cyc(4);
        chk("drop_no_strobe", neuron_enable, 0);
        run = 1'b1;
        @(negedge clk);
        chk("rerun_step", step_count, 0);
        chk("rerun_spk", spike_count, 0);

        // Asynchronous reset with a commit in flight
        cyc(3);
        wr(1, 9);
        cfg_valid = 1'b1; cfg_addr = 3'd5;
        @(posedge clk);
        #2 reset = 1'b1;
        cfg_valid = 1'b0;
        run = 1'b0;
        #1;
        chk("arst_thr", threshold, 64);
        chk("arst_pend", commit_pending, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_en", neuron_enable, 0);
        chk("arst_step", step_count, 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        wr(5, 0);
        cyc(1);
        chk("arst_decay_shadow", decay, 1);
        chk("arst_thr_shadow", threshold, 64);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsnn_ctrl.md
# rsnn_ctrl

Configuration and timestep controller for a single recurrent spiking neuron. It holds the neuron's four parameters (threshold, decay, refractory period, feedback scale) in double-buffered registers. It generates the periodic one-cycle `enable` strobe that advances the neuron by one timestep, and counts the output spikes the neuron reports. Parameter updates are written over a byte-wide valid/ready port and take effect atomically at a timestep boundary, so a neuron update never sees a mix of old and new parameters.

## Interface

Parameters:
- `STEP_CNT_W`, default 16: width of the timestep counter `step_count`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  a configuration write is offered.
- `cfg_ready`  out  1  controller can accept a write. A write is accepted when `cfg_valid && cfg_ready` at an edge.
- `cfg_addr`  in  3  register address.
- `cfg_data`  in  8  write data.
- `run`  in  1  level; high = generate timesteps.
- `spike_in`  in  1  neuron spike output.
- `neuron_enable`  out  1  one-cycle timestep strobe to the neuron.
- `threshold`, `decay`, `refractory_period`, `feedback_scale`  out  8 each  active neuron parameters.
- `spike_count`  out  8  spikes counted since the last run start; saturates at 255.
- `step_count`  out  `STEP_CNT_W`  timesteps issued since the last run start; wraps.
- `commit_pending`  out  1  a commit has been requested and not yet applied.

## Operation

- Register map. Writes go to the shadow registers; the active registers drive the outputs.
  - 0 threshold: reset 64
  - 1 decay: reset 1
  - 2 refractory_period: reset 2
  - 3 feedback_scale: reset 0
  - 4 step_period: reset 0
  - 5 commit: data ignored; sets `commit_pending`
  - 6, 7: accepted and ignored
- Commit copies all five shadow registers to the active registers in one edge, then clears `commit_pending`.
- `cfg_ready` = !`commit_pending`. While a commit is pending, shadow writes are blocked.
- FSM states:
  - IDLE → RUN on an edge where `run`=1. Entry clears the prescaler, `spike_count` and `step_count`.
  - RUN → IDLE on an edge where `run`=0. Prescaler cleared; `neuron_enable` is 0 from that edge.
- Prescaler (RUN only): 8-bit `cnt` increments each cycle. When `cnt` == active step_period, the next edge sets `neuron_enable`=1 for exactly one cycle and sets `cnt` to 0. Strobe spacing is therefore step_period+1 cycles; step_period=0 gives `neuron_enable` continuously high.
- `step_count` increments on every edge that raises a strobe.
- Spike sampling: `spike_in` is sampled exactly once per timestep, in the cycle after each strobe cycle. A sample of 1 increments `spike_count`, saturating at 255.
- Commit application:
  - IDLE: at the next edge after acceptance.
  - RUN: at the edge ending a strobe cycle. The update strobed in that cycle uses the old parameters; the next timestep uses the new values, including the new step_period.
- Commit accepted in RUN, then `run` drops before the boundary: applied at the first edge in IDLE.
- Reset: all registers return to their reset values, state IDLE, `neuron_enable`=0, `cfg_ready`=1, `commit_pending`=0, both counters 0.

## Timing

- Writes: zero-wait whenever `cfg_ready`=1; one write per cycle maximum.
- Shadow write to active output: 1 cycle in IDLE; in RUN, ≤ step_period+2 cycles after the commit is accepted.
- First strobe: step_period+1 cycles after the edge that enters RUN. Example: step_period=3, RUN entered at edge E0 → `neuron_enable` high in the cycle after E4.
- Write to addr 5 while `commit_pending`=1: cannot be accepted (`cfg_ready`=0).
- A boundary edge that coincides with a `run` fall still applies the pending commit.
- `reset` asserted mid-operation: outputs take their reset values immediately (asynchronously); any pending commit is discarded.

## Test plan

- Reset → threshold=64, decay=1, refractory_period=2, feedback_scale=0, `neuron_enable`=0, `cfg_ready`=1, both counts 0.
- IDLE: write addr0=100, then addr5 → threshold unchanged until commit, becomes 100 one cycle after commit is accepted; `cfg_ready` low for exactly 1 cycle.
- Commit step_period=3, `run`=1 for 20 cycles → strobe every 4 cycles, first strobe 4 cycles after RUN entry; `step_count` = 5 at end.
- RUN, step_period=3: write threshold=90 and commit mid-step → the current strobe uses the old value; threshold=90 at the edge ending that strobe; `cfg_ready` low until then and a `cfg_valid` held high is not accepted.
- step_period=0, `spike_in` tied to 1 for 300 cycles → `spike_count` saturates at 255 and stays there; `step_count` = 300 (one strobe per cycle).
- Drop `run` at cycle 2 of a 4-cycle step with a commit pending → no further strobe; commit applied at the first IDLE edge; raising `run` again clears both counters.
